// File: rtl/cla_pipe_addsub.sv
// Two-stage pipelined WIDTH-bit adder/subtractor built from 4-bit carry-lookahead groups.
// Stage 1 registers bit and group propagate/generate terms; stage 2 resolves carries and flags.
module cla_pipe_addsub #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic             sub_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] s_o,
  output logic             cout_o,
  output logic             v_o,
  output logic             z_o
);

  localparam int NG = WIDTH / 4;

  // Stage 1 state
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] p_q, g_q;
  logic [NG-1:0]    gp_q, gg_q;
  logic             c0_q, amsb_q, bxmsb_q;

  // Stage 2 state
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s_q;
  logic             cout_q, v_q, z_q;

  // Handshake
  logic s2_free, advance, accept;

  assign s2_free    = ~s2_valid_q | out_ready_i;
  assign advance    = s1_valid_q & s2_free;
  assign in_ready_o = ~s1_valid_q | s2_free;
  assign accept     = in_valid_i & in_ready_o;

  // Stage 1 combinational terms
  logic [WIDTH-1:0] bx, p_d, g_d;
  logic [NG-1:0]    gp_d, gg_d;
  logic             c0_d;

  assign bx   = sub_i ? ~b_i : b_i;
  assign p_d  = a_i ^ bx;
  assign g_d  = a_i & bx;
  assign c0_d = sub_i | cin_i;

  generate
    for (genvar gi = 0; gi < NG; gi++) begin : g_grp_pg
      assign gp_d[gi] = &p_d[4*gi+3 -: 4];
      assign gg_d[gi] = g_d[4*gi+3]
                      | (p_d[4*gi+3] & g_d[4*gi+2])
                      | (p_d[4*gi+3] & p_d[4*gi+2] & g_d[4*gi+1])
                      | (p_d[4*gi+3] & p_d[4*gi+2] & p_d[4*gi+1] & g_d[4*gi]);
    end
  endgenerate

  // Second-level lookahead: each group carry is an independent sum of products over
  // all lower groups, so no carry depends on another group carry.
  logic [NG:0] gc;
  logic        sop, prod;

  always_comb begin
    gc    = '0;
    sop   = 1'b0;
    prod  = 1'b0;
    gc[0] = c0_q;
    for (int k = 0; k < NG; k++) begin
      sop = c0_q;
      for (int m = 0; m <= k; m++) sop = sop & gp_q[m];
      for (int j = 0; j <= k; j++) begin
        prod = gg_q[j];
        for (int m = j + 1; m <= k; m++) prod = prod & gp_q[m];
        sop = sop | prod;
      end
      gc[k+1] = sop;
    end
  end

  // In-group carries from registered p/g and the resolved group carry-in
  logic [WIDTH-1:0] cb;

  generate
    for (genvar gi = 0; gi < NG; gi++) begin : g_grp_carry
      assign cb[4*gi]   = gc[gi];
      assign cb[4*gi+1] = g_q[4*gi] | (p_q[4*gi] & gc[gi]);
      assign cb[4*gi+2] = g_q[4*gi+1]
                        | (p_q[4*gi+1] & g_q[4*gi])
                        | (p_q[4*gi+1] & p_q[4*gi] & gc[gi]);
      assign cb[4*gi+3] = g_q[4*gi+2]
                        | (p_q[4*gi+2] & g_q[4*gi+1])
                        | (p_q[4*gi+2] & p_q[4*gi+1] & g_q[4*gi])
                        | (p_q[4*gi+2] & p_q[4*gi+1] & p_q[4*gi] & gc[gi]);
    end
  endgenerate

  logic [WIDTH-1:0] s_d;
  logic             cout_d, v_d, z_d;

  assign s_d    = p_q ^ cb;
  assign cout_d = gc[NG];
  assign v_d    = (amsb_q == bxmsb_q) & (s_d[WIDTH-1] != amsb_q);
  assign z_d    = ~|s_d;

  // A beat moving into stage 2 keeps it valid even when the old result is consumed
  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    if (accept)       s1_valid_d = 1'b1;
    else if (advance) s1_valid_d = 1'b0;
    if (advance)          s2_valid_d = 1'b1;
    else if (out_ready_i) s2_valid_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      s1_valid_q <= 1'b0;
      p_q        <= '0;
      g_q        <= '0;
      gp_q       <= '0;
      gg_q       <= '0;
      c0_q       <= 1'b0;
      amsb_q     <= 1'b0;
      bxmsb_q    <= 1'b0;
      s2_valid_q <= 1'b0;
      s_q        <= '0;
      cout_q     <= 1'b0;
      v_q        <= 1'b0;
      z_q        <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      if (accept) begin
        p_q     <= p_d;
        g_q     <= g_d;
        gp_q    <= gp_d;
        gg_q    <= gg_d;
        c0_q    <= c0_d;
        amsb_q  <= a_i[WIDTH-1];
        bxmsb_q <= bx[WIDTH-1];
      end
      if (advance) begin
        s_q    <= s_d;
        cout_q <= cout_d;
        v_q    <= v_d;
        z_q    <= z_d;
      end
    end
  end

  assign out_valid_o = s2_valid_q;
  assign s_o         = s_q;
  assign cout_o      = cout_q;
  assign v_o         = v_q;
  assign z_o         = z_q;

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Table-driven bench for cla_pipe_addsub: directed vectors, backpressure, mid-flight reset,
// and a random flow-controlled run scored against an A + Bx + c0 reference.
module tb_cla_pipe_addsub;

  logic        clk, reset_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] a, b, s;
  logic        cin, sub, cout, v, z;

  cla_pipe_addsub #(.WIDTH(16)) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .a_i(a), .b_i(b), .cin_i(cin), .sub_i(sub),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .s_o(s), .cout_o(cout), .v_o(v), .z_o(z)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a, b;
    logic        cin, sub;
    logic [15:0] s;
    logic        cout, v, z;
  } vec_t;

  typedef struct packed {
    logic [15:0] s;
    logic        cout, v, z;
  } res_t;

  localparam int NV = 10;
  vec_t vecs [NV];
  res_t q [$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_result(input string name, input res_t e);
    chk(name, {13'b0, cout, v, z, s}, {13'b0, e.cout, e.v, e.z, e.s});
  endtask

  function automatic res_t vec_res(input vec_t t);
    res_t r;
    r.s = t.s; r.cout = t.cout; r.v = t.v; r.z = t.z;
    return r;
  endfunction

  function automatic res_t model(input logic [15:0] ma, input logic [15:0] mb,
                                 input logic mcin, input logic msub);
    res_t        r;
    logic [15:0] bx;
    logic [16:0] t;
    bx = msub ? ~mb : mb;
    t  = {1'b0, ma} + {1'b0, bx} + {16'b0, (msub ? 1'b1 : mcin)};
    r.s    = t[15:0];
    r.cout = t[16];
    r.v    = (ma[15] == bx[15]) && (t[15] != ma[15]);
    r.z    = (t[15:0] == 16'h0000);
    return r;
  endfunction

  task automatic drive_vec(input int i);
    a = vecs[i].a; b = vecs[i].b; cin = vecs[i].cin; sub = vecs[i].sub;
  endtask

  // One beat with Out_ready held high: accept, then result after the second edge
  task automatic apply_vec(input int i);
    @(negedge clk);
    drive_vec(i);
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1 chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk($sformatf("vec%0d_lat1_valid", i), 32'(out_valid), 32'd0);
    @(negedge clk);
    #1 chk($sformatf("vec%0d_lat2_valid", i), 32'(out_valid), 32'd1);
    check_result($sformatf("vec%0d_result", i), vec_res(vecs[i]));
    $display("vec %0d: A=%h B=%h cin=%0b sub=%0b -> S=%h C=%0b V=%0b Z=%0b",
             i, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, s, cout, v, z);
  endtask

  int acc, sent, cyc;
  logic acc_flag;
  localparam int NRAND = 300;
  localparam int LIMIT = 5000;

  initial begin
    clk = 1'b0; reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;

    //             a         b         cin   sub   s         cout  v     z
    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{16'h0FFF, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
    vecs[9] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0};

    // Reset state
    #3;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    check_result("rst_outputs", '0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < NV; i++) apply_vec(i);

    // Backpressure: offer 4 beats with the consumer stalled
    @(negedge clk);
    out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid = (acc < 4);
      if (acc < 4) drive_vec(acc);
      #1;
      if (c >= 2) begin
        chk($sformatf("bp_hold_valid%0d", c), 32'(out_valid), 32'd1);
        check_result($sformatf("bp_hold_result%0d", c), vec_res(vecs[0]));
      end
      if (in_valid && in_ready) acc++;
      @(negedge clk);
    end
    chk("bp_accepts", 32'(acc), 32'd2);
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      in_valid = (acc < 4);
      if (acc < 4) drive_vec(acc);
      #1;
      if (c < 4) begin
        chk($sformatf("bp_drain_valid%0d", c), 32'(out_valid), 32'd1);
        check_result($sformatf("bp_drain_result%0d", c), vec_res(vecs[c]));
        $display("bp beat %0d: S=%h C=%0b V=%0b Z=%0b", c, s, cout, v, z);
      end else begin
        chk("bp_drain_done", 32'(out_valid), 32'd0);
      end
      if (in_valid && in_ready) acc++;
      @(negedge clk);
    end
    chk("bp_total_accepts", 32'(acc), 32'd4);

    // Reset with both stages full
    out_ready = 1'b0;
    drive_vec(4);
    in_valid = 1'b1;
    @(negedge clk);
    drive_vec(5);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("rm_full_valid", 32'(out_valid), 32'd1);
    chk("rm_full_in_ready", 32'(in_ready), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    chk("rm_out_valid", 32'(out_valid), 32'd0);
    chk("rm_in_ready", 32'(in_ready), 32'd1);
    check_result("rm_outputs", '0);
    $display("reset mid-flight: out_valid=%0b S=%h", out_valid, s);
    @(negedge clk);
    reset_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1 chk($sformatf("rm_no_stale%0d", c), 32'(out_valid), 32'd0);
    end
    apply_vec(6);

    // Random flow-controlled run against the reference model
    sent = 0; cyc = 0; acc_flag = 1'b0; in_valid = 1'b0;
    while ((sent < NRAND || q.size() != 0) && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
      if (!in_valid || acc_flag) begin
        in_valid = 1'b0;
        if (sent < NRAND && $urandom_range(3) != 0) begin
          a = 16'($urandom); b = 16'($urandom);
          cin = 1'($urandom); sub = 1'($urandom);
          in_valid = 1'b1;
        end
      end
      out_ready = ($urandom_range(2) != 0);
      #1;
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("rnd_spurious_valid", 32'(out_valid), 32'd0);
        end else begin
          check_result("rnd_result", q[0]);
          if (out_ready) begin
            $display("rnd beat: S=%h C=%0b V=%0b Z=%0b", s, cout, v, z);
            void'(q.pop_front());
          end
        end
      end
      acc_flag = in_valid && in_ready;
      if (acc_flag) begin
        q.push_back(model(a, b, cin, sub));
        sent++;
      end
    end
    if (cyc >= LIMIT) begin
      checks++;
      errors++;
      $display("FAIL rnd_timeout: got %0d beats pending expected 0", q.size());
    end
    in_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
